// File: rtl/uart_rx_oversampled_if.sv
// ----------------------------------------------------------------------------
// uart_rx_oversampled_if
//   Output bundle of the oversampled UART receiver.
//   master : driven by the receiver (data_out, valid, framing_error,
//            state_leds, started, and parity_error when UART_RX_PARITY_EN
//            is defined).
//   slave  : consumer / board side, same signals as inputs.
//   Parameter N : data bits per frame.
//   Macro UART_RX_PARITY_EN : adds parity_error and widens state_leds to 5.
// ----------------------------------------------------------------------------
interface uart_rx_oversampled_if #(
   parameter int N = 8
);
`ifdef UART_RX_PARITY_EN
   localparam int LED_W = 5;
`else
   localparam int LED_W = 4;
`endif

   logic [N-1:0]     data_out;
   logic             valid;
   logic             framing_error;
`ifdef UART_RX_PARITY_EN
   logic             parity_error;
`endif
   logic [LED_W-1:0] state_leds;
   logic             started;

   modport master (
      output data_out,
      output valid,
      output framing_error,
`ifdef UART_RX_PARITY_EN
      output parity_error,
`endif
      output state_leds,
      output started
   );

   modport slave (
      input data_out,
      input valid,
      input framing_error,
`ifdef UART_RX_PARITY_EN
      input parity_error,
`endif
      input state_leds,
      input started
   );
endinterface

// File: rtl/uart_rx_oversampled.sv
// ----------------------------------------------------------------------------
// uart_rx_oversampled
//   Oversampling asynchronous serial receiver, 8N1 by default, LSB first.
//   The line is sampled on an external oversampling tick; a half-bit offset
//   taken in START puts every later sample at mid-bit.
//
//   Ports:
//     clk    : system clock
//     reset  : asynchronous, active-high reset
//     tick   : oversampling strobe, COUNT_TICKS per bit period
//     rx     : serial line, idle high
//     rx_if  : master modport carrying data_out, valid, framing_error,
//              state_leds (one-hot FSM state), started (FSM not idle)
//
//   Parameters:
//     N           : data bits per frame (1..16)
//     COUNT_TICKS : oversampling ticks per bit (even, >= 4)
//
//   Optional feature macro UART_RX_PARITY_EN:
//     adds an even-parity bit/state between DATA and STOP, a parity_error
//     pulse, and state_leds bit4 for the PARITY state.
// ----------------------------------------------------------------------------
module uart_rx_oversampled #(
   parameter int N           = 8,
   parameter int COUNT_TICKS = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  tick,
   input  logic                  rx,
   uart_rx_oversampled_if.master rx_if
);

   localparam int SW = $clog2(COUNT_TICKS);
   localparam int NW = (N > 1) ? $clog2(N) : 1;
`ifdef UART_RX_PARITY_EN
   localparam int LED_W = 5;
`else
   localparam int LED_W = 4;
`endif

   localparam logic [SW-1:0] S_HALF = SW'(COUNT_TICKS / 2 - 1);
   localparam logic [SW-1:0] S_LAST = SW'(COUNT_TICKS - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);

   localparam logic [LED_W-1:0] LED_IDLE  = LED_W'(5'b00001);
   localparam logic [LED_W-1:0] LED_START = LED_W'(5'b00010);
   localparam logic [LED_W-1:0] LED_DATA  = LED_W'(5'b00100);
   localparam logic [LED_W-1:0] LED_STOP  = LED_W'(5'b01000);
`ifdef UART_RX_PARITY_EN
   localparam logic [LED_W-1:0] LED_PAR   = LED_W'(5'b10000);
`endif

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      ST_PARITY = 3'd4,
`endif
      ST_STOP   = 3'd3
   } state_t;

   state_t           state_r;
   logic             rx_meta_r;
   logic             rx_sync_r;
   logic [SW-1:0]    s_r;
   logic [NW-1:0]    n_r;
   logic [N-1:0]     shift_r;
   logic [N-1:0]     data_r;
   logic             valid_r;
   logic             ferr_r;
   logic [LED_W-1:0] leds_r;
   logic             started_r;
`ifdef UART_RX_PARITY_EN
   logic             par_r;
   logic             perr_r;
`endif

   // Shift one sampled bit in at the MSB end; after N bits the first bit
   // received sits in bit 0 (LSB-first framing). Written without a slice so
   // it also holds for N = 1.
   function automatic logic [N-1:0] shift_in(input logic [N-1:0] cur,
                                             input logic         bit_in);
      logic [N-1:0] tmp;
      tmp        = cur >> 1;
      tmp[N-1]   = bit_in;
      return tmp;
   endfunction

`ifdef UART_RX_PARITY_EN
   // Even parity: data bits plus parity bit must hold an even number of ones.
   function automatic logic even_parity_ok(input logic [N-1:0] d,
                                           input logic         p);
      return ~(^d ^ p);
   endfunction
`endif

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
      end
   end

   // Receiver FSM with counters, shift register and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         s_r       <= SW'(0);
         n_r       <= NW'(0);
         shift_r   <= N'(0);
         data_r    <= N'(0);
         valid_r   <= 1'b0;
         ferr_r    <= 1'b0;
         leds_r    <= LED_IDLE;
         started_r <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_r     <= 1'b0;
         perr_r    <= 1'b0;
`endif
      end else begin
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_r  <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               // Start edge is taken without waiting for a tick so a line
               // still low after a bad stop bit re-enters START at once.
               if (!rx_sync_r) begin
                  state_r   <= ST_START;
                  leds_r    <= LED_START;
                  started_r <= 1'b1;
                  s_r       <= SW'(0);
               end
            end
            ST_START: begin
               if (tick) begin
                  if (s_r == S_HALF) begin
                     s_r <= SW'(0);
                     if (!rx_sync_r) begin
                        state_r <= ST_DATA;
                        leds_r  <= LED_DATA;
                        n_r     <= NW'(0);
                     end else begin
                        // Line went back high before mid start bit: glitch.
                        state_r   <= ST_IDLE;
                        leds_r    <= LED_IDLE;
                        started_r <= 1'b0;
                     end
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
            ST_DATA: begin
               if (tick) begin
                  if (s_r == S_LAST) begin
                     s_r     <= SW'(0);
                     shift_r <= shift_in(shift_r, rx_sync_r);
                     if (n_r == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                        state_r <= ST_PARITY;
                        leds_r  <= LED_PAR;
`else
                        state_r <= ST_STOP;
                        leds_r  <= LED_STOP;
`endif
                     end else begin
                        n_r <= n_r + NW'(1);
                     end
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
               if (tick) begin
                  if (s_r == S_LAST) begin
                     s_r     <= SW'(0);
                     par_r   <= rx_sync_r;
                     state_r <= ST_STOP;
                     leds_r  <= LED_STOP;
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
`endif
            ST_STOP: begin
               if (tick) begin
                  if (s_r == S_LAST) begin
                     s_r       <= SW'(0);
                     state_r   <= ST_IDLE;
                     leds_r    <= LED_IDLE;
                     started_r <= 1'b0;
                     // Framing error takes priority so at most one pulse fires.
                     if (!rx_sync_r) begin
                        ferr_r <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     end else if (!even_parity_ok(shift_r, par_r)) begin
                        perr_r <= 1'b1;
`endif
                     end else begin
                        data_r  <= shift_r;
                        valid_r <= 1'b1;
                     end
                  end else begin
                     s_r <= s_r + SW'(1);
                  end
               end
            end
            default: begin
               state_r   <= ST_IDLE;
               leds_r    <= LED_IDLE;
               started_r <= 1'b0;
               s_r       <= SW'(0);
               n_r       <= NW'(0);
            end
         endcase
      end
   end

   assign rx_if.data_out      = data_r;
   assign rx_if.valid         = valid_r;
   assign rx_if.framing_error = ferr_r;
   assign rx_if.state_leds    = leds_r;
   assign rx_if.started       = started_r;
`ifdef UART_RX_PARITY_EN
   assign rx_if.parity_error  = perr_r;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_oversampled
//   Directed bench for uart_rx_oversampled (N = 8, COUNT_TICKS = 16, tick
//   every 4 clk, so one bit = 64 clk). Expected pulses are queued by the
//   stimulus and consumed by an independent monitor.
// ----------------------------------------------------------------------------
module tb_uart_rx_oversampled;

   localparam int BIT_CLK = 64;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   logic tick  = 1'b0;
   logic rx    = 1'b1;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int valid_cnt = 0;
   int last_valid_cyc = 0;

   typedef struct {
      int         kind;   // 0 = valid with data, 1 = framing error
      logic [7:0] data;
   } exp_t;

   exp_t       exp_q[$];
   logic [3:0] led_log[$];
   logic [3:0] led_prev = 4'b0001;
   bit         log_en = 1'b0;

   uart_rx_oversampled_if #(.N(8)) bus ();

   uart_rx_oversampled #(.N(8), .COUNT_TICKS(16)) dut (
      .clk   (clk),
      .reset (reset),
      .tick  (tick),
      .rx    (rx),
      .rx_if (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Oversampling tick: one clk wide, every 4 clk.
   initial begin
      int k;
      k = 0;
      forever begin
         @(negedge clk);
         k = k + 1;
         tick = ((k % 4) == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT emits a pulse.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (bus.valid && bus.framing_error)
               check("pulse_exclusive", 32'd1, 32'd0);
            if (bus.valid || bus.framing_error) begin
               if (bus.valid) begin
                  valid_cnt++;
                  last_valid_cyc = cyc;
               end
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_pulse: got valid=%b ferr=%b data=%0h expected none",
                           bus.valid, bus.framing_error, bus.data_out);
               end else begin
                  bad = bad; // count already taken for the pop itself
                  e = exp_q.pop_front();
                  check("pulse_kind", {31'd0, bus.framing_error}, e.kind);
                  if (e.kind == 0)
                     check("pulse_data", {24'd0, bus.data_out}, {24'd0, e.data});
               end
            end
            if (log_en && (bus.state_leds[3:0] !== led_prev)) begin
               led_log.push_back(bus.state_leds[3:0]);
               led_prev = bus.state_leds[3:0];
            end
         end
      end
   end

   task automatic drive_bit(input logic v, input int clocks);
      rx = v;
      repeat (clocks) @(negedge clk);
   endtask

   task automatic idle(input int clocks);
      rx = 1'b1;
      repeat (clocks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                             input int stop_len);
      drive_bit(1'b0, BIT_CLK);
      for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
      drive_bit(stop_lvl, stop_len);
      rx = 1'b1;
   endtask

   initial begin
      int start_cyc;
      int lat;
      int vc;
      int seq[4];
      seq = '{2, 4, 8, 1};

      // Reset held 10 clk with idle line.
      reset = 1'b1;
      rx    = 1'b1;
      repeat (10) @(negedge clk);
      check("rst_data_out", {24'd0, bus.data_out}, 32'h00);
      check("rst_valid", {31'd0, bus.valid}, 32'd0);
      check("rst_ferr", {31'd0, bus.framing_error}, 32'd0);
      check("rst_leds", {28'd0, bus.state_leds[3:0]}, 32'h1);
      check("rst_started", {31'd0, bus.started}, 32'd0);
      reset = 1'b0;
      idle(200);
      check("idle_no_valid", valid_cnt, 0);
      check("idle_leds", {28'd0, bus.state_leds[3:0]}, 32'h1);

      // Single frame 0x52 with latency check.
      exp_q.push_back('{0, 8'h52});
      start_cyc = cyc;
      send_frame(8'h52, 1'b1, BIT_CLK);
      idle(BIT_CLK);
      check("r_data_out", {24'd0, bus.data_out}, 32'h52);
      check("r_one_pulse", valid_cnt, 1);
      lat = last_valid_cyc - start_cyc;
      check("r_latency_in_window", {31'd0, (lat >= 600 && lat <= 624)}, 32'd1);
      idle(200);
      check("r_data_hold", {24'd0, bus.data_out}, 32'h52);

      // Back-to-back frames, zero idle gap, LED walk recorded.
      led_log.delete();
      led_prev = 4'b0001;
      log_en   = 1'b1;
      exp_q.push_back('{0, 8'h00});
      exp_q.push_back('{0, 8'hFF});
      exp_q.push_back('{0, 8'hA5});
      send_frame(8'h00, 1'b1, BIT_CLK);
      send_frame(8'hFF, 1'b1, BIT_CLK);
      send_frame(8'hA5, 1'b1, BIT_CLK);
      idle(BIT_CLK);
      log_en = 1'b0;
      check("b2b_data_out", {24'd0, bus.data_out}, 32'hA5);
      check("b2b_pulses", valid_cnt, 4);
      check("b2b_led_log_len", led_log.size(), 12);
      for (int i = 0; i < led_log.size() && i < 12; i++)
         check("b2b_led_walk", {28'd0, led_log[i]}, seq[i % 4]);

      // Low glitch of 3 tick periods on idle line.
      led_log.delete();
      led_prev = 4'b0001;
      log_en   = 1'b1;
      drive_bit(1'b0, 12);
      idle(2 * BIT_CLK);
      log_en = 1'b0;
      check("glitch_led_log_len", led_log.size(), 2);
      if (led_log.size() == 2) begin
         check("glitch_start_seen", {28'd0, led_log[0]}, 32'h2);
         check("glitch_back_idle", {28'd0, led_log[1]}, 32'h1);
      end
      check("glitch_no_valid", valid_cnt, 4);
      check("glitch_data_hold", {24'd0, bus.data_out}, 32'hA5);

      // Frame 0x3C with stop bit low for the sampled part of the bit.
      exp_q.push_back('{1, 8'h00});
      send_frame(8'h3C, 1'b0, 48);
      idle(3 * BIT_CLK);
      check("ferr_no_valid", valid_cnt, 4);
      check("ferr_data_hold", {24'd0, bus.data_out}, 32'hA5);
      check("ferr_leds_idle", {28'd0, bus.state_leds[3:0]}, 32'h1);

      // Reset during DATA bit 4 of 0x81.
      vc = valid_cnt;
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b1, BIT_CLK);
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b0, BIT_CLK);
      drive_bit(1'b0, 32);
      check("abort_started_before", {31'd0, bus.started}, 32'd1);
      reset = 1'b1;
      rx    = 1'b1;
      repeat (4) @(negedge clk);
      check("abort_data_cleared", {24'd0, bus.data_out}, 32'h00);
      check("abort_leds_idle", {28'd0, bus.state_leds[3:0]}, 32'h1);
      check("abort_started", {31'd0, bus.started}, 32'd0);
      reset = 1'b0;
      idle(2 * BIT_CLK);
      check("abort_no_valid", valid_cnt, vc);
      exp_q.push_back('{0, 8'h81});
      send_frame(8'h81, 1'b1, BIT_CLK);
      idle(2 * BIT_CLK);
      check("after_abort_data", {24'd0, bus.data_out}, 32'h81);
      check("after_abort_pulses", valid_cnt, vc + 1);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_oversampled.md
Name: uart_rx_oversampled

Overview:
- Oversampling asynchronous serial receiver for the MIPS debug/UART link; 8N1 by default, LSB first.
- Samples the serial line on an externally supplied oversampling tick from the shared baud-rate generator.
- Delivers each received byte with a one-cycle valid pulse.
- Also exposes the FSM state and a busy flag for board LEDs.

Parameters:
- N, 8, data bits per frame (1..16).
- COUNT_TICKS, 16, oversampling ticks per bit period (even, >=4).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- tick  input  1  oversampling strobe, one clk cycle wide, COUNT_TICKS per bit.
- rx  input  1  serial line, idle high.
- data_out  output  N  last correctly framed byte; holds until the next good frame.
- valid  output  1  one-clk pulse when data_out is updated.
- framing_error  output  1  one-clk pulse when the stop bit is sampled low.
- state_leds  output  4  one-hot FSM state: bit0 IDLE, bit1 START, bit2 DATA, bit3 STOP.
- started  output  1  high while the FSM is not in IDLE.

Behaviour:
- One clock domain; reset asynchronous, active-high, affecting every flop.
- Reset values:
  - FSM in IDLE.
  - data_out = 0, valid = 0, framing_error = 0.
  - state_leds = 4'b0001, started = 0.
  - Synchronizer flops = 1.
  - Tick counter s = 0, bit counter n = 0.
- rx passes through a 2-flop synchronizer (rx_s) before use; this adds 2 clk of latency.
- Counters:
  - s counts ticks, width clog2(COUNT_TICKS).
  - n counts data bits, width clog2(N).
  - A shift register of N bits assembles the byte.
- IDLE:
  - On rx_s == 0 (no tick needed): go to START, s = 0.
- START (on tick only):
  - If s == COUNT_TICKS/2-1 and rx_s == 0: go to DATA, s = 0, n = 0.
  - If s == COUNT_TICKS/2-1 and rx_s == 1: treat as a glitch, return to IDLE with no pulse.
  - Otherwise s++.
- DATA (on tick only):
  - When s == COUNT_TICKS-1: s = 0, shift = {rx_s, shift[N-1:1]} (LSB first).
  - If n == N-1, go to STOP; otherwise n++.
  - Otherwise s++.
- STOP (on tick only):
  - When s == COUNT_TICKS-1: if rx_s == 1, then data_out <= shift and valid pulses for 1 clk.
  - If rx_s == 0 at that point: framing_error pulses for 1 clk and data_out is unchanged.
  - Either way, go to IDLE.
  - Otherwise s++.
- All sampling happens at mid-bit, because of the half-bit offset taken in START.
- Cycles without tick hold s, n and the shift register unchanged.
- valid and framing_error are never asserted in the same cycle.
- Both pulses are registered outputs and deassert the following cycle.
- If the line is still low after STOP (break condition), IDLE re-enters START immediately; no lockup.
- Reset asserted mid-frame aborts the frame: no valid pulse, and data_out is cleared to 0.
- tick asserted continuously is legal; each clk then counts as one tick.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - Adds state PARITY between DATA and STOP; state_leds widens to 5, with bit4 = PARITY.
  - Samples one even-parity bit at mid-bit.
  - Adds output parity_error (1 bit), a one-clk pulse at the end of STOP when the received parity mismatches.
  - When parity_error pulses, valid is suppressed and data_out is held.
- Undefined:
  - No PARITY state, no parity_error port; plain 8N1 as above.

Test Plan:
- Reset held 10 clk, rx = 1 -> data_out = 0x00, valid = 0, state_leds = 4'b0001, started = 0; after release, idle line gives no pulses.
- tick every 4 clk, COUNT_TICKS = 16, send 0x52 ('R') 8N1 -> exactly one valid pulse about 10 bit times after start edge; data_out = 0x52 and holds until the next frame.
- Back-to-back frames 0x00, 0xFF, 0xA5 with zero idle gap -> three valid pulses in order with data_out = 0x00, 0xFF, 0xA5; state_leds walks through 0001 -> 0010 -> 0100 -> 1000 for each frame.
- Low glitch of 3 tick periods on idle line -> returns to IDLE from START; no valid or framing_error pulse; data_out unchanged.
- Frame 0x3C with stop bit forced low -> framing_error pulses once; valid stays 0; data_out keeps its previous value.
- Reset asserted during DATA bit 4 of 0x81 -> immediate IDLE, data_out = 0x00, no valid; the next full frame 0x81 is received correctly.
